// File: rtl/sync_fifo_buffer.sv
// Single-clock circular-buffer FIFO with first-word-fall-through reads and a
// saturating free-space count for upstream stages that issue several entries per cycle.
module sync_fifo_buffer #(
    parameter  int DEPTH    = 16,
    parameter  int WIDTH    = 32,
    parameter  int MAX_CNT  = 3,
    localparam int CNT_BITS = $clog2(MAX_CNT + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_valid,
    output logic                wr_valid,
    output logic [CNT_BITS-1:0] spots,
    output logic                full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_free;

    // Handshake: wr_valid/rd_valid mean the request is accepted this cycle and
    // state moves on the next rising edge; there is no write-to-read bypass.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full     = (r_count == CNT_W'(DEPTH));
        wr_valid = wr_en && !full;
        rd_valid = rd_en && (r_count != '0);
        rd_data  = rd_valid ? r_mem[r_head] : '0;
        w_free   = CNT_W'(DEPTH) - r_count;
        spots    = (w_free >= CNT_W'(MAX_CNT)) ? CNT_BITS'(MAX_CNT) : CNT_BITS'(w_free);
    end

    // Storage carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (wr_valid) begin
            r_mem[r_tail] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (wr_valid) begin
                r_tail <= next_ptr(r_tail);
            end
            if (rd_valid) begin
                r_head <= next_ptr(r_head);
            end
            case ({wr_valid, rd_valid})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Self-checking bench for sync_fifo_buffer: occupancy model plus a data
// scoreboard fed at write time and drained whenever the FIFO reports a read.
module tb_sync_fifo_buffer;

    localparam int DEPTH    = 16;
    localparam int WIDTH    = 32;
    localparam int MAX_CNT  = 3;
    localparam int CNT_BITS = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic                wr_en;
    logic [WIDTH-1:0]    wr_data;
    logic                rd_en;
    logic [WIDTH-1:0]    rd_data;
    logic                rd_valid;
    logic                wr_valid;
    logic [CNT_BITS-1:0] spots;
    logic                full;

    logic [WIDTH-1:0] exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    int               m_count = 0;
    logic             exp_wr = 1'b0;
    logic             exp_rd = 1'b0;

    sync_fifo_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_CNT(MAX_CNT)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_valid (wr_valid),
        .spots    (spots),
        .full     (full)
    );

    always #5 clock = ~clock;

    // Scoreboard: every accepted read must return the oldest accepted write.
    always @(negedge clock) begin : sb_monitor
        logic [WIDTH-1:0] e;
        if (!reset && rd_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: rd_data=%h but no entry expected", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_err++;
                    $display("FAIL sb_data: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    // Driver: apply one cycle of stimulus and stop at mid-cycle for checks.
    task automatic cycle(input logic we, input logic [WIDTH-1:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        exp_wr  = we && (m_count != DEPTH);
        exp_rd  = re && (m_count != 0);
        if (exp_wr) exp_q.push_back(wd);
        @(negedge clock);
    endtask

    task automatic tick();
        @(posedge clock);
        if (exp_wr) m_count++;
        if (exp_rd) m_count--;
        exp_wr = 1'b0;
        exp_rd = 1'b0;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b1; wr_data = '0;
        #3;
        n_cmp++;
        if (rd_valid !== 1'b0 || wr_valid !== 1'b0 || rd_data !== '0 || full !== 1'b0 || spots !== 2'd3) begin
            n_err++;
            $display("FAIL reset_outputs: rv=%b wv=%b rd=%h full=%b spots=%0d, need 0 0 0 0 3",
                     rd_valid, wr_valid, rd_data, full, spots);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        cycle(1'b0, '0, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== '0 || spots !== 2'd3 || full !== 1'b0) begin
            n_err++;
            $display("FAIL empty_read: rv=%b rd=%h spots=%0d full=%b, need 0 0 3 0",
                     rd_valid, rd_data, spots, full);
        end
        tick();
        cycle(1'b0, '0, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL empty_read_again: rv=%b need 0 (count must stay 0)", rd_valid);
        end
        tick();
    endtask

    task automatic test_write_read();
        cycle(1'b1, 32'hCAFE_0001, 1'b0);
        n_cmp++;
        if (wr_valid !== 1'b1) begin n_err++; $display("FAIL wr_accept: wv=%b need 1", wr_valid); end
        tick();
        cycle(1'b0, '0, 1'b0);
        tick();
        cycle(1'b0, '0, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rd_after_idle: rv=%b need 1", rd_valid); end
        tick();
        cycle(1'b1, 32'hCAFE_0002, 1'b0);
        tick();
        cycle(1'b0, '0, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rd_next_cycle: rv=%b need 1", rd_valid); end
        tick();
    endtask

    task automatic test_simul_empty();
        cycle(1'b1, 32'h0000_00A0, 1'b1);
        n_cmp++;
        if (wr_valid !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
            n_err++;
            $display("FAIL no_bypass: wv=%b rv=%b rd=%h, need 1 0 0", wr_valid, rd_valid, rd_data);
        end
        tick();
        for (int i = 1; i <= 4; i++) begin cycle(1'b1, 32'h0000_00A0 + i, 1'b0); tick(); end
        for (int i = 0; i < 3; i++) begin cycle(1'b0, '0, 1'b1); tick(); end
        cycle(1'b0, '0, 1'b0);
        n_cmp++;
        if (spots !== 2'd3 || full !== 1'b0) begin
            n_err++;
            $display("FAIL count2_spots: spots=%0d full=%b, need 3 0", spots, full);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1);
            n_cmp++;
            if (rd_valid !== (i < 2)) begin
                n_err++;
                $display("FAIL drain_count2[%0d]: rv=%b need %b", i, rd_valid, (i < 2));
            end
            tick();
        end
    endtask

    task automatic test_fill_full();
        logic [CNT_BITS-1:0] sp_tab [DEPTH];
        for (int c = 0; c < DEPTH; c++) sp_tab[c] = (c <= 13) ? 2'd3 : (c == 14) ? 2'd2 : 2'd1;
        for (int c = 0; c < DEPTH; c++) begin
            cycle(1'b1, 32'h1000_0000 + c, 1'b0);
            n_cmp++;
            if (spots !== sp_tab[c] || full !== 1'b0 || wr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL fill[%0d]: spots=%0d full=%b wv=%b, need %0d 0 1",
                         c, spots, full, wr_valid, sp_tab[c]);
            end
            tick();
        end
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        n_cmp++;
        if (full !== 1'b1 || spots !== 2'd0 || wr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL write_when_full: full=%b spots=%0d wv=%b, need 1 0 0", full, spots, wr_valid);
        end
        tick();
    endtask

    task automatic test_full_rdwr();
        cycle(1'b1, 32'hBAD0_0001, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b1 || wr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_rdwr: rv=%b wv=%b, need 1 0", rd_valid, wr_valid);
        end
        tick();
        cycle(1'b1, 32'h2000_0015, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b1 || wr_valid !== 1'b1 || spots !== 2'd1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL count15_rdwr: rv=%b wv=%b spots=%0d full=%b, need 1 1 1 0",
                     rd_valid, wr_valid, spots, full);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, '0, 1'b1);
            n_cmp++;
            if (rd_valid !== (i < 15)) begin
                n_err++;
                $display("FAIL drain15[%0d]: rv=%b need %b", i, rd_valid, (i < 15));
            end
            tick();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_leftover: %0d entries never read, need 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h3000_0000 + i, 1'b1);
            n_cmp++;
            if (rd_valid !== (i > 0) || wr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b[%0d]: rv=%b wv=%b, need %b 1", i, rd_valid, wr_valid, (i > 0));
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, '0, 1'b1);
            n_cmp++;
            if (rd_valid !== (i == 0)) begin
                n_err++;
                $display("FAIL b2b_tail[%0d]: rv=%b need %b", i, rd_valid, (i == 0));
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin cycle(1'b1, 32'h4000_0000 + i, 1'b0); tick(); end
        #2;
        reset = 1'b1;
        rd_en = 1'b1;
        #1;
        n_cmp++;
        if (full !== 1'b0 || spots !== 2'd3 || rd_valid !== 1'b0 || rd_data !== '0) begin
            n_err++;
            $display("FAIL mid_reset: full=%b spots=%0d rv=%b rd=%h, need 0 3 0 0",
                     full, spots, rd_valid, rd_data);
        end
        exp_q.delete();
        m_count = 0;
        @(posedge clock); #3;
        reset = 1'b0;
        @(posedge clock); #1;
        cycle(1'b0, '0, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL read_after_reset: rv=%b need 0", rd_valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic                we;
        logic                re;
        logic [CNT_BITS-1:0] exp_sp;
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 75 : 30));
            re = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 75));
            exp_sp = (DEPTH - m_count >= MAX_CNT) ? CNT_BITS'(MAX_CNT) : CNT_BITS'(DEPTH - m_count);
            cycle(we, WIDTH'($urandom), re);
            n_cmp++;
            if (wr_valid !== exp_wr || rd_valid !== exp_rd || spots !== exp_sp ||
                full !== (m_count == DEPTH)) begin
                n_err++;
                $display("FAIL random[%0d]: wv=%b rv=%b spots=%0d full=%b, need %b %b %0d %b",
                         i, wr_valid, rd_valid, spots, full, exp_wr, exp_rd, exp_sp, (m_count == DEPTH));
            end
            tick();
        end
        while (m_count != 0) begin cycle(1'b0, '0, 1'b1); tick(); end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_leftover: %0d entries never read, need 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simul_empty();
        test_fill_full();
        test_full_rdwr();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
